// File: rtl/ula_logic_pipe_if.sv
// Operand/result handshake bundle for ula_logic_pipe.
// slave is the block's view; master is the producer/consumer view.
interface ula_logic_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [2:0]         in_op;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_res;
    logic               out_zero;
    logic               out_par;
    logic               out_ones;
    logic [2:0]         out_op;

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_res, out_zero, out_par, out_ones, out_op
    );

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_res, out_zero, out_par, out_ones, out_op
    );
endinterface

// File: rtl/ula_logic_pipe.sv
// Two-stage pipelined logic unit: S1 holds operands, S2 holds the zero-extended
// result and its flags; valid/ready with full backpressure, plus a handshake counter.
module ula_logic_pipe #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    ula_logic_pipe_if.slave    bus,
    output logic [COUNT_W-1:0] op_count
);
    logic               s1_v;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    logic [2:0]         s1_op;

    logic               s2_v;
    logic [2*WIDTH-1:0] s2_res;
    logic               s2_zero;
    logic               s2_par;
    logic               s2_ones;
    logic [2:0]         s2_op;

    logic [COUNT_W-1:0] cnt;

    logic               s2_adv;
    logic               in_rdy;
    logic               in_fire;
    logic               out_fire;
    logic [WIDTH-1:0]   alu;

    // in_ready depends only on stage valids and out_ready, never on in_valid
    always_comb begin
        s2_adv   = s1_v & (~s2_v | bus.out_ready);
        in_rdy   = ~s1_v | s2_adv;
        in_fire  = bus.in_valid & in_rdy;
        out_fire = s2_v & bus.out_ready;
    end

    always_comb begin
        alu = '0;
        case (s1_op)
            3'b000:  alu = s1_a & s1_b;
            3'b001:  alu = s1_a | s1_b;
            3'b010:  alu = ~(s1_a & s1_b);
            3'b011:  alu = s1_a ^ s1_b;
            3'b100:  alu = ~(s1_a | s1_b);
            3'b101:  alu = ~(s1_a ^ s1_b);
            3'b110:  alu = ~s1_a;
            default: alu = s1_a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_op   <= '0;
            s2_v    <= 1'b0;
            s2_res  <= '0;
            s2_zero <= 1'b1;
            s2_par  <= 1'b0;
            s2_ones <= 1'b0;
            s2_op   <= '0;
            cnt     <= '0;
        end else begin
            if (in_fire) begin
                s1_v  <= 1'b1;
                s1_a  <= bus.in_a;
                s1_b  <= bus.in_b;
                s1_op <= bus.in_op;
            end else if (s2_adv) begin
                s1_v  <= 1'b0;
            end

            // Flags are registered alongside the result so they always describe out_res
            if (s2_adv) begin
                s2_v    <= 1'b1;
                s2_res  <= {{WIDTH{1'b0}}, alu};
                s2_zero <= (alu == '0);
                s2_par  <= ^alu;
                s2_ones <= &alu;
                s2_op   <= s1_op;
            end else if (out_fire) begin
                s2_v    <= 1'b0;
            end

            if (out_fire)
                cnt <= cnt + COUNT_W'(1);
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = s2_v;
    assign bus.out_res   = s2_res;
    assign bus.out_zero  = s2_zero;
    assign bus.out_par   = s2_par;
    assign bus.out_ones  = s2_ones;
    assign bus.out_op    = s2_op;
    assign op_count      = cnt;
endmodule

// File: tb/tb_ula_logic_pipe.sv
// Scoreboard bench for ula_logic_pipe: stimulus pushes modelled results,
// a negedge monitor pops and compares on every output handshake.
module tb_ula_logic_pipe;
    localparam int W  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] op_count;

    always #5 clk = ~clk;

    ula_logic_pipe_if #(.WIDTH(W)) bus ();

    ula_logic_pipe #(.WIDTH(W), .COUNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .op_count (op_count)
    );

    typedef struct packed {
        logic [2*W-1:0] res;
        logic           zero;
        logic           par;
        logic           ones;
        logic [2:0]     op;
    } beat_t;

    beat_t sb[$];
    int    tests_run    = 0;
    int    tests_failed = 0;
    int    model_count  = 0;
    bit    done;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: complements are taken as (2^W-1)-x, parity by counting set bits
    function automatic beat_t model(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
        beat_t e;
        int    full = (1 << W) - 1;
        int    ia   = int'(a);
        int    ib   = int'(b);
        int    r;
        int    n    = 0;
        case (op)
            3'd0:    r = ia & ib;
            3'd1:    r = ia | ib;
            3'd2:    r = full - (ia & ib);
            3'd3:    r = ia ^ ib;
            3'd4:    r = full - (ia | ib);
            3'd5:    r = full - (ia ^ ib);
            3'd6:    r = full - ia;
            default: r = ia;
        endcase
        for (int i = 0; i < W; i++) n += (r >> i) & 1;
        e.res  = (2*W)'(r);
        e.zero = (r == 0);
        e.par  = (n % 2) == 1;
        e.ones = (r == full);
        e.op   = op;
        return e;
    endfunction

    beat_t held;
    bit    held_v = 1'b0;

    always @(negedge clk) begin
        beat_t act;
        beat_t exp;
        act = {bus.out_res, bus.out_zero, bus.out_par, bus.out_ones, bus.out_op};
        if (rst) begin
            sb.delete();
            model_count = 0;
            held_v      = 1'b0;
        end else begin
            if (bus.in_valid)
                assert (!$isunknown(bus.in_op)) else $error("in_op unknown while in_valid");
            check("op_count", 32'(op_count), 32'(model_count % (1 << CW)));
            if (held_v) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_stable", 32'(act), 32'(held));
            end
            held_v = bus.out_valid && !bus.out_ready;
            held   = act;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_beat: got res 0x%0h op %0d, expected no beat", bus.out_res, bus.out_op);
                end else begin
                    exp = sb.pop_front();
                    check("result", 32'(act), 32'(exp));
                end
                model_count++;
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.in_a, bus.in_b, bus.in_op));
        end
    end

    // Called at posedge+2; returns at posedge+2 after the beat's accepting edge
    task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
        bit ok = 1'b0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1 within 200 cycles");
        end
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain", 32'(ok), 32'd1);
        @(posedge clk);
        #2;
    endtask

    task automatic directed(string nm, logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op,
                            logic [15:0] e_res, logic e_zero, logic e_par, logic e_ones);
        bus.out_ready = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_op     = op;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        check({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({nm, "_not_early"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({nm, "_res"}, 32'(bus.out_res), 32'(e_res));
        check({nm, "_flags"}, {29'd0, bus.out_zero, bus.out_par, bus.out_ones},
              {29'd0, e_zero, e_par, e_ones});
        check({nm, "_op"}, 32'(bus.out_op), 32'(op));
        @(posedge clk);
        #2;
        drain();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1500000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_res", 32'(bus.out_res), 32'd0);
        check("rst_flags", {29'd0, bus.out_zero, bus.out_par, bus.out_ones}, 32'b100);
        check("rst_out_op", 32'(bus.out_op), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #2;

        directed("and",  8'hF0, 8'h3C, 3'b000, 16'h0030, 1'b0, 1'b0, 1'b0);
        directed("nand", 8'hAA, 8'h55, 3'b010, 16'h00FF, 1'b0, 1'b0, 1'b1);
        directed("xor",  8'h5A, 8'h5A, 3'b011, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Random traffic with random backpressure and input gaps
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        bus.in_valid = 1'b0;
                        @(posedge clk);
                        #2;
                    end
                    send(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
                end
                bus.in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #2;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        // Six-beat stream with a three-cycle stall in the middle
        c0 = model_count;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(W'($urandom), W'($urandom), 3'(i));
                bus.in_valid = 1'b0;
            end
            begin
                @(posedge clk);
                #2;
                @(posedge clk);
                #2;
                bus.out_ready = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", 32'(bus.in_ready), 32'd0);
                check("stall_out_valid", 32'(bus.out_valid), 32'd1);
                @(posedge clk);
                #2;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("stream_op_count", 32'(op_count), 32'((c0 + 6) % (1 << CW)));

        // Reset with two beats held in the pipe
        bus.out_ready = 1'b0;
        send(8'h12, 8'h34, 3'b001);
        send(8'h56, 8'h78, 3'b111);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("inflight_held", {30'd0, bus.out_valid, bus.in_ready}, 32'b10);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_op_count", 32'(op_count), 32'd0);
        check("mid_rst_zero", 32'(bus.out_zero), 32'd1);
        check("mid_rst_res", 32'(bus.out_res), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_ghost_beat", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #2;

        // Counter wrap: 65535 handshakes, then one more
        for (int i = 0; i < 65535; i++)
            send(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
        drain();
        check("count_full", 32'(op_count), 32'h0000_FFFF);
        send(8'hFF, 8'h0F, 3'b110);
        drain();
        check("count_wrap", 32'(op_count), 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
